alu_wide_seq: RTL
=================

Name: alu_wide_seq

Overview:
Multi-cycle sequencer that runs one 16-bit 74181-based ALU slice (4x 74181 + one 74182 CLA, all combinational) over WORDS consecutive 16-bit words. This performs wide (WORDS*16-bit) arithmetic and logic operations.
Words are processed LSB-first, one per clock, and the carry is chained through a register between cycles.
Request and result use valid/ready handshakes. The block sits between the instruction/control logic and the shared ALU datapath.

Parameters:
WORDS, 4, number of 16-bit words per operand (total width WORDS*16); legal range 2..16
IDXW, 4, width of the word index counter; must satisfy 2^IDXW >= WORDS

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_s  in  4  74181 function select S3..S0
req_m  in  1  74181 mode (1 = logic, 0 = arithmetic)
req_cin  in  1  logical carry-in (1 = carry); ignored when req_m = 1
req_a  in  WORDS*16  operand A
req_b  in  WORDS*16  operand B
alu_a  out  16  current A word to ALU
alu_b  out  16  current B word to ALU
alu_s  out  4  function select to ALU
alu_m  out  1  mode to ALU
alu_cn  out  1  ALU Cn pin, active-low carry (0 = carry in)
alu_f  in  16  ALU result (combinational from alu_* in the same cycle)
alu_cn16  in  1  ALU Cn+16 pin, active-low carry out (0 = carry out)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res  out  WORDS*16  wide result
res_cout  out  1  logical carry-out of top word (1 = carry); 0 in logic mode
res_zero  out  1  1 when res is all zeros

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst = 1 at an edge) forces the following, regardless of current state, including mid-RUN: state = IDLE, idx = 0, res = 0, res_cout = 0, res_zero = 0, res_valid = 0, carry register = 1 (no carry), captured operands/op = 0. The in-flight operation is discarded and produces no result.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1, capture req_a, req_b, req_s, req_m. Set the carry register to ~req_cin, or to 1 if req_m = 1. Set idx = 0 and go to RUN.
  - res is cleared to 0 on acceptance.
- RUN:
  - req_ready = 0.
  - alu_a/alu_b = captured word idx (bits idx*16 +: 16).
  - alu_s/alu_m = captured op; alu_cn = carry register.
  - At each edge: res word idx <= alu_f, carry register <= alu_cn16, idx <= idx + 1.
  - When idx = WORDS-1 at the edge, go to DONE.
  - In DONE, res_cout = ~(last alu_cn16) if the captured m = 0, else 0. res_zero is computed from the final res.
- DONE:
  - res_valid = 1; res, res_cout and res_zero are held stable.
  - On an edge with res_ready = 1, go to IDLE and drop res_valid.
  - req_ready stays 0 in DONE; a request is not accepted in the same cycle the result is taken.
- Latency: acceptance edge T gives res_valid = 1 from edge T+WORDS. Throughput is one operation per WORDS+2 cycles when res_ready is held at 1.
- Outside RUN, the ALU drive is idle: alu_a = alu_b = 0, alu_s = 0, alu_m = 1, alu_cn = 1.
- req_valid asserted in RUN or DONE is ignored and the request is not captured. The requester must hold it until it sees req_ready = 1.
- Captured operands are unaffected by req_* changes after acceptance.
- Carry polarity follows the 74181 active-high-data convention throughout (Cn and Cn+16 are active-low). The chain passes alu_cn16 straight to the next alu_cn without inversion.
- The ALU path is purely combinational; alu_f/alu_cn16 must settle within one clk period of alu_* changing.

Test Plan:
- Add all-ones plus one: WORDS=4, A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0001, S=1001, M=0, cin=0. Required: res=0, res_cout=1, res_zero=1, res_valid exactly 4 cycles after acceptance; alu_cn sequence 1,0,0,0.
- Subtract with borrow: A=5, B=7, S=0110, M=0, cin=1 (A minus B). Required: res=0xFFFF_FFFF_FFFF_FFFE, res_cout=0, res_zero=0.
- Logic XOR: A=0x1234_5678_9ABC_DEF0, B=0xFFFF_0000_FFFF_0000, S=0110, M=1, cin=1. Required: res=0xEDCB_5678_6543_DEF0, res_cout=0; alu_cn=1 on every RUN cycle.
- Backpressure and overlap: res_ready=0 for 10 cycles with req_valid held at 1 and new operands on req_*. Required: res stable, req_ready=0 throughout, second request accepted only after res_ready=1 and return to IDLE; second result matches the new operands.
- Reset mid-run: rst=1 at the edge after the second RUN cycle. Required: next cycle state IDLE, req_ready=1, res_valid=0, res=0, alu_m=1, alu_cn=1; a following add of 3+4 yields 7.

Source files
------------

// File: rtl/alu_wide_seq_if.sv
// Bundle of request, result and ALU-slice signals for the wide ALU sequencer.
// The slave modport is the sequencer; the master side is requester, consumer and ALU slice.
interface alu_wide_seq_if #(
    parameter int unsigned WORDS = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [3:0]             req_s;
    logic                   req_m;
    logic                   req_cin;
    logic [WORDS*16-1:0]    req_a;
    logic [WORDS*16-1:0]    req_b;

    logic [15:0]            alu_a;
    logic [15:0]            alu_b;
    logic [3:0]             alu_s;
    logic                   alu_m;
    logic                   alu_cn;
    logic [15:0]            alu_f;
    logic                   alu_cn16;

    logic                   res_valid;
    logic                   res_ready;
    logic [WORDS*16-1:0]    res;
    logic                   res_cout;
    logic                   res_zero;

    modport slave (
        input  req_valid, req_s, req_m, req_cin, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_s, alu_m, alu_cn,
        input  alu_f, alu_cn16,
        output res_valid, res, res_cout, res_zero,
        input  res_ready
    );

    modport master (
        output req_valid, req_s, req_m, req_cin, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_s, alu_m, alu_cn,
        output alu_f, alu_cn16,
        input  res_valid, res, res_cout, res_zero,
        output res_ready
    );
endinterface

// File: rtl/alu_wide_seq.sv
// Runs a 16-bit 74181/74182 ALU slice over WORDS words LSB-first, chaining the
// active-low carry through a register, to build a WORDS*16-bit operation.
module alu_wide_seq #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned IDXW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_wide_seq_if.slave bus
);
    localparam int unsigned W = WORDS * 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [IDXW-1:0]   idx;
    logic [W-1:0]      op_a, op_b;
    logic [3:0]        op_s;
    logic              op_m;
    logic              carry;
    logic [W-1:0]      res_r, res_upd;
    logic              res_cout_r, res_zero_r;
    logic              last;

    assign last = (idx == IDXW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_s     = '0;
        bus.alu_m     = 1'b1;
        bus.alu_cn    = 1'b1;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = RUN;
            end
            RUN: begin
                bus.alu_a  = op_a[idx*16 +: 16];
                bus.alu_b  = op_b[idx*16 +: 16];
                bus.alu_s  = op_s;
                bus.alu_m  = op_m;
                bus.alu_cn = carry;
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result with the current word merged in, so the zero flag sees the final value.
    always_comb begin
        res_upd                = res_r;
        res_upd[idx*16 +: 16]  = bus.alu_f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_s       <= '0;
            op_m       <= 1'b0;
            carry      <= 1'b1;
            res_r      <= '0;
            res_cout_r <= 1'b0;
            res_zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_a       <= bus.req_a;
                        op_b       <= bus.req_b;
                        op_s       <= bus.req_s;
                        op_m       <= bus.req_m;
                        carry      <= bus.req_m | ~bus.req_cin;
                        idx        <= '0;
                        res_r      <= '0;
                        res_cout_r <= 1'b0;
                        res_zero_r <= 1'b0;
                    end
                end
                RUN: begin
                    res_r <= res_upd;
                    carry <= bus.alu_cn16;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        res_cout_r <= ~op_m & ~bus.alu_cn16;
                        res_zero_r <= (res_upd == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res      = res_r;
    assign bus.res_cout = res_cout_r;
    assign bus.res_zero = res_zero_r;
endmodule
